// File: rtl/ifetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue.
//   XLEN          - address / instruction width the entry layout is built for
//   INSTR_BYTES   - fetch stride in bytes
//   fetch_entry_t - one prefetch-queue entry {pc, instr}
//   cnt_width()   - width of a counter that must hold 0..depth inclusive
package ifetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Bundle of the fetch stage's external handshakes: redirect input,
// instruction-memory request/response channels and the decoder channel.
//   master - the fetch stage (drives requests and the decoder head)
//   slave  - the environment (memory, decoder and branch unit)
interface ifetch_queue_if #(
    parameter int n = 32
);
    logic         redirect_valid;
    logic [n-1:0] redirect_pc;

    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [n-1:0] imem_req_addr;

    logic         imem_rsp_valid;
    logic [n-1:0] imem_rsp_data;

    logic         dec_valid;
    logic         dec_ready;
    logic [n-1:0] dec_instr;
    logic [n-1:0] dec_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  dec_ready,
        output imem_req_valid, imem_req_addr,
        output dec_valid, dec_instr, dec_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output dec_ready,
        input  imem_req_valid, imem_req_addr,
        input  dec_valid, dec_instr, dec_pc
    );

endinterface

// File: rtl/ifetch_queue_fifo.sv
// Small synchronous FIFO used as the prefetch queue.
//   clk, rst   - clock, asynchronous active-high reset
//   push_i     - write wdata_i at the tail
//   pop_i      - advance the head
//   flush_i    - empty the FIFO (wins over push/pop)
//   wdata_i    - tail data
//   rdata_o    - head data (storage is reset, so it reads 0 after reset)
//   count_o    - current occupancy, 0..DEPTH
module sync_fifo
    import ifetch_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order word requests
// to instruction memory, buffers returned words tagged with their PC and
// hands them to the decoder. A redirect flushes the queue and marks every
// outstanding request as stale so its response is dropped on arrival.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - ifetch_queue_if master: redirect, imem req/rsp, decoder head
// The queue entry layout comes from ifetch_pkg, so n must equal XLEN.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int           n        = XLEN,
    parameter int           DEPTH    = 4,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    ifetch_queue_if.master  bus
);

    localparam int           CW      = cnt_width(DEPTH);
    localparam logic [CW:0]  DEPTH_C = DEPTH[CW:0];
    localparam logic [n-1:0] STEP    = n'(INSTR_BYTES);

    logic [n-1:0]  fetch_pc_q, fetch_pc_d;
    logic [n-1:0]  rsp_pc_q,   rsp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q,  discard_d;

    logic [CW-1:0] occ;
    logic [CW-1:0] live;
    logic [CW:0]   credit_used;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_ok;
    logic          push;
    logic          pop;
    logic [n-1:0]  target;
    fetch_entry_t  wentry;
    fetch_entry_t  head;
    logic [$bits(fetch_entry_t)-1:0] fifo_rdata;

    assign target = bus.redirect_pc & ~n'(3);

    // Every live request already owns a queue slot, so the queue can
    // never overflow however responses bunch up.
    assign live        = inflight_q - discard_q;
    assign credit_used = {1'b0, occ} + {1'b0, live};
    assign req_valid   = !rst && !bus.redirect_valid
                         && (credit_used < DEPTH_C)
                         && ({1'b0, inflight_q} < DEPTH_C);
    assign req_fire    = req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is a protocol error; it is ignored.
    assign rsp_ok = bus.imem_rsp_valid && (inflight_q != '0);
    assign push   = !bus.redirect_valid && rsp_ok && (discard_q == '0);
    assign pop    = bus.dec_valid && bus.dec_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        if (bus.redirect_valid) begin
            // Everything still outstanding after this cycle is stale,
            // including nothing from the response dropped right now.
            fetch_pc_d = target;
            rsp_pc_d   = target;
            inflight_d = inflight_q - CW'(rsp_ok);
            discard_d  = inflight_q - CW'(rsp_ok);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + STEP;
            if (rsp_ok) begin
                if (discard_q != '0) discard_d = discard_q - CW'(1);
                else                 rsp_pc_d  = rsp_pc_q + STEP;
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    assign wentry.pc    = rsp_pc_q;
    assign wentry.instr = bus.imem_rsp_data;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .wdata_i (wentry),
        .rdata_o (fifo_rdata),
        .count_o (occ)
    );

    assign head = fetch_entry_t'(fifo_rdata);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.dec_valid      = (occ != '0) && !bus.redirect_valid;
    assign bus.dec_instr      = head.instr;
    assign bus.dec_pc         = head.pc;

    a_rsp_without_request: assert property (
        @(posedge clk) disable iff (rst) bus.imem_rsp_valid |-> (inflight_q != '0));

    a_push_when_full: assert property (
        @(posedge clk) disable iff (rst) push |-> ({1'b0, occ} < DEPTH_C));

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    import ifetch_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ifetch_queue_if #(.n(32)) bus ();

    ifetch_queue #(.n(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [31:0] addr; int gen; int stamp; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    pend_t mem_q[$];   // accepted requests awaiting a response (memory model)
    exp_t  exp_q[$];   // words the decoder must still see, oldest first
    int    gen;        // bumps on every redirect/reset; older requests are stale
    int    n_ret;      // leading exp_q entries whose data has already returned
    logic [31:0] next_req;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fire_cnt = 0, pop_cnt = 0, last_fire_cyc = 0, last_pop_cyc = 0;
    logic [31:0] last_fire_addr, last_pop_pc;
    int fires_since_rst = 0;
    logic [31:0] first_addr_since_rst;

    int p_ready = 0, p_rsp = 0, p_dec = 0, p_redir = 0, rsp_budget = -1;
    logic force_redir = 1'b0;
    logic [31:0] force_target = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        bus.imem_req_ready = ($urandom_range(0, 99) < p_ready);
        if (mem_q.size() > 0 && mem_q[0].stamp < cyc && rsp_budget != 0
            && $urandom_range(0, 99) < p_rsp) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(mem_q[0].addr);
            if (rsp_budget > 0) rsp_budget--;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        bus.dec_ready = ($urandom_range(0, 99) < p_dec);
        if (force_redir) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = force_target;
            force_redir        = 1'b0;
        end else if ($urandom_range(0, 99) < p_redir) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = $urandom;
        end else begin
            bus.redirect_valid = 1'b0;
            bus.redirect_pc    = $urandom;
        end
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Monitor / reference model: sees each cycle's handshakes at the falling
    // edge, checks the DUT against the model, then advances the model.
    always @(negedge clk) begin : monitor
        logic redir, fire, rsp, pop, exp_rv, exp_dv;
        pend_t p;
        if (rst) begin
            mem_q.delete();
            exp_q.delete();
            n_ret = 0;
            gen++;
            next_req = RESET_PC;
            fires_since_rst = 0;
        end else begin
            redir = bus.redirect_valid;
            fire  = bus.imem_req_valid && bus.imem_req_ready;
            rsp   = bus.imem_rsp_valid;
            pop   = bus.dec_valid && bus.dec_ready;

            exp_rv = !redir && (exp_q.size() < DEPTH) && (mem_q.size() < DEPTH);
            chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
            if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, next_req);

            exp_dv = !redir && (n_ret > 0);
            chk("dec_valid", {31'b0, bus.dec_valid}, {31'b0, exp_dv});
            if (bus.dec_valid && exp_dv) begin
                chk("dec_pc", bus.dec_pc, exp_q[0].pc);
                chk("dec_instr", bus.dec_instr, exp_q[0].instr);
            end

            if (fire) begin
                fire_cnt++;
                last_fire_cyc  = cyc;
                last_fire_addr = bus.imem_req_addr;
                if (fires_since_rst == 0) first_addr_since_rst = bus.imem_req_addr;
                fires_since_rst++;
            end
            if (pop) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                last_pop_pc  = bus.dec_pc;
            end

            if (redir) begin
                if (rsp && mem_q.size() > 0) void'(mem_q.pop_front());
                gen++;
                exp_q.delete();
                n_ret    = 0;
                next_req = bus.redirect_pc & ~32'h3;
            end else begin
                if (pop && n_ret > 0) begin
                    void'(exp_q.pop_front());
                    n_ret--;
                end
                if (rsp && mem_q.size() > 0) begin
                    p = mem_q.pop_front();
                    if (p.gen == gen) n_ret++;
                end
                if (fire) begin
                    mem_q.push_back('{addr: bus.imem_req_addr, gen: gen, stamp: cyc});
                    exp_q.push_back('{pc: next_req, instr: instr_of(next_req)});
                    next_req = next_req + 32'd4;
                end
            end
        end
    end

    initial begin
        int snap, snap_pop, bound;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.dec_ready      = 1'b0;

        // Reset values.
        #2 rst = 1'b1;
        #1;
        chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("rst_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
        chk("rst_dec_instr", bus.dec_instr, 32'd0);
        chk("rst_dec_pc", bus.dec_pc, 32'd0);
        steps(2);
        step();
        rst = 1'b0;

        // Streaming: always ready, minimum latency, decoder always ready.
        p_ready = 100; p_rsp = 100; p_dec = 100; p_redir = 0;
        steps(10);
        snap_pop = pop_cnt;
        steps(20);
        chk("steady_rate", pop_cnt - snap_pop, 20);

        // Drain.
        p_ready = 0;
        steps(8);

        // Decoder stalled: fill to exactly DEPTH requests.
        p_ready = 100; p_dec = 0;
        snap = fire_cnt;
        steps(12);
        chk("fill_fires", fire_cnt - snap, DEPTH);
        snap = fire_cnt;
        p_dec = 100;
        step();
        p_dec = 0;
        steps(6);
        chk("refill_fires", fire_cnt - snap, 1);
        chk("refill_cycle", last_fire_cyc, last_pop_cyc + 1);

        // Redirect with three stale requests in flight and one queued word.
        p_ready = 0; p_dec = 100;
        steps(8);
        p_dec = 0; p_rsp = 0; p_ready = 100;
        force_redir = 1'b1; force_target = 32'h10;
        step();
        steps(6);
        rsp_budget = 1; p_rsp = 100;
        steps(3);
        p_rsp = 0; rsp_budget = -1;
        force_redir = 1'b1; force_target = 32'h203;
        snap = fire_cnt;
        snap_pop = pop_cnt;
        step();
        p_rsp = 100; p_dec = 100;
        step();
        @(negedge clk); #1;
        chk("redir_fires", fire_cnt - snap, 1);
        chk("redir_addr", last_fire_addr, 32'h200);
        bound = 0;
        while (pop_cnt == snap_pop && bound < 20) begin
            step();
            bound++;
        end
        @(negedge clk); #1;
        chk("redir_popped", {31'b0, pop_cnt != snap_pop}, 32'd1);
        if (pop_cnt - snap_pop == 1) chk("redir_first_pc", last_pop_pc, 32'h200);

        // Redirect colliding with a response and a pending request.
        p_ready = 100; p_rsp = 100; p_dec = 0;
        steps(6);
        p_dec = 100;
        steps(6);
        @(negedge clk); #1;
        snap = fire_cnt;
        force_redir = 1'b1; force_target = 32'h400;
        step();
        @(negedge clk); #1;
        chk("redir_no_fire", fire_cnt - snap, 0);
        steps(10);

        // Address wrap at the top of the space.
        force_redir = 1'b1; force_target = 32'hFFFF_FFF8;
        steps(14);

        // Randomised traffic.
        p_ready = 70; p_rsp = 60; p_dec = 70; p_redir = 3;
        steps(3000);

        // Reset mid-stream.
        p_redir = 0; p_ready = 100; p_rsp = 50; p_dec = 0;
        steps(4);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        chk("midrst_dec_valid", {31'b0, bus.dec_valid}, 32'd0);
        chk("midrst_dec_pc", bus.dec_pc, 32'd0);
        p_ready = 0; p_rsp = 0;
        steps(2);
        step();
        rst = 1'b0;
        p_ready = 100; p_rsp = 100; p_dec = 100;
        steps(4);
        @(negedge clk); #1;
        chk("postrst_fired", {31'b0, fires_since_rst != 0}, 32'd1);
        chk("postrst_addr", first_addr_since_rst, RESET_PC);
        steps(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
